// File: rtl/fft_pkg.sv
// Shared sizing, derived constants and types for the FFT bar binner.
package fft_pkg;
    localparam int FFT_POINTS = 1024;
    localparam int DATA_W     = 24;
    localparam int EXP_W      = 6;
    localparam int NUM_BARS   = 16;
    localparam int MAG_W      = 16;

    localparam int BIN_W     = $clog2(FFT_POINTS);
    localparam int BAR_W     = $clog2(NUM_BARS);
    localparam int BAR_SHIFT = $clog2(FFT_POINTS / (2 * NUM_BARS));

    typedef logic [MAG_W-1:0] bar_bank_t [NUM_BARS];

    typedef enum logic [1:0] {IDLE, COLLECT, FLUSH} state_t;

    // The most negative input has no positive twin, so it folds onto the largest positive value.
    function automatic logic [DATA_W-1:0] abs_sat(input logic signed [DATA_W-1:0] v);
        if (v == {1'b1, {(DATA_W-1){1'b0}}})
            return {1'b0, {(DATA_W-1){1'b1}}};
        else if (v < 0)
            return -v;
        else
            return v;
    endfunction
endpackage

// File: rtl/fft_mag_approx.sv
// Abs, alpha-max-beta-min magnitude and block-exponent shift/saturate; 3 cycles, 1 beat/cycle.
// No stall path: kill drops the beats already in flight so a restarted frame sees none of them.
module fft_mag_approx
    import fft_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     kill,
    input  logic                     beat_vld,
    input  logic signed [DATA_W-1:0] re,
    input  logic signed [DATA_W-1:0] im,
    input  logic signed [EXP_W-1:0]  exp_v,
    input  logic [BIN_W-1:0]         idx,
    output logic                     mag_vld,
    output logic [MAG_W-1:0]         mag,
    output logic [BIN_W-1:0]         mag_idx
);
    logic              s1_vld, s2_vld;
    logic [DATA_W-1:0] s1_a, s1_b;
    logic [DATA_W:0]   s2_m;
    logic [BIN_W-1:0]  s1_idx, s2_idx;

    logic [DATA_W:0]   m_approx;
    logic [EXP_W:0]    e_ext, e_abs;
    logic [4:0]        sh;
    logic [63:0]       wide;
    logic [MAG_W-1:0]  sat;

    always_comb begin
        m_approx = (s1_a > s1_b) ? ({1'b0, s1_a} + {3'b000, s1_b[DATA_W-1:2]})
                                 : ({1'b0, s1_b} + {3'b000, s1_a[DATA_W-1:2]});
    end

    // Negative exponent scales up, positive scales down; shift distance capped at 31.
    always_comb begin
        e_ext = {exp_v[EXP_W-1], exp_v};
        e_abs = e_ext[EXP_W] ? (~e_ext + 1'b1) : e_ext;
        sh    = (e_abs > 31) ? 5'd31 : e_abs[4:0];
        wide  = e_ext[EXP_W] ? ({{(63-DATA_W){1'b0}}, s2_m} << sh)
                             : ({{(63-DATA_W){1'b0}}, s2_m} >> sh);
        sat   = (|wide[63:MAG_W]) ? {MAG_W{1'b1}} : wide[MAG_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_vld  <= 1'b0;
            s2_vld  <= 1'b0;
            mag_vld <= 1'b0;
            s1_a    <= '0;
            s1_b    <= '0;
            s2_m    <= '0;
            mag     <= '0;
            s1_idx  <= '0;
            s2_idx  <= '0;
            mag_idx <= '0;
        end else begin
            s1_vld  <= beat_vld;
            s2_vld  <= s1_vld && !kill;
            mag_vld <= s2_vld && !kill;
            s1_a    <= abs_sat(re);
            s1_b    <= abs_sat(im);
            s1_idx  <= idx;
            s2_m    <= m_approx;
            s2_idx  <= s1_idx;
            mag     <= sat;
            mag_idx <= s2_idx;
        end
    end
endmodule

// File: rtl/fft_bar_binner.sv
// Frames FFT beats, max-holds positive bins into bars, commits whole frames; eop -> frame_done in 5 cycles.
// in_ready drops only during the 4-cycle drain after a complete frame.
module fft_bar_binner
    import fft_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    input  logic                     in_sop,
    input  logic                     in_eop,
    input  logic [1:0]               in_error,
    input  logic signed [DATA_W-1:0] in_real,
    input  logic signed [DATA_W-1:0] in_imag,
    input  logic signed [EXP_W-1:0]  in_exp,
    output logic                     in_ready,
    input  logic [BAR_W-1:0]         rd_bar,
    output logic [MAG_W-1:0]         rd_mag,
    output logic                     frame_done,
    output logic                     sync_err
);
    localparam logic [BIN_W-1:0] LAST_BEAT = BIN_W'(FFT_POINTS - 1);

    state_t                  state, state_n;
    logic [BIN_W-1:0]        cnt, cnt_n, idx;
    logic [1:0]              fcnt, fcnt_n;
    logic                    bad, bad_n;
    logic signed [EXP_W-1:0] exp_q;
    logic                    accept, take, start, discard, commit, flush_err;

    logic                    p_vld;
    logic [MAG_W-1:0]        p_mag;
    logic [BIN_W-1:0]        p_idx;
    logic [BAR_W-1:0]        p_bar;
    bar_bank_t               work, bank;

    assign in_ready = !reset && (state != FLUSH);
    assign accept   = in_valid && in_ready;
    assign p_bar    = BAR_W'(p_idx >> BAR_SHIFT);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            fcnt  <= '0;
            bad   <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            fcnt  <= fcnt_n;
            bad   <= bad_n;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        fcnt_n    = fcnt;
        bad_n     = bad;
        idx       = cnt;
        take      = 1'b0;
        start     = 1'b0;
        discard   = 1'b0;
        commit    = 1'b0;
        flush_err = 1'b0;
        case (state)
            IDLE, COLLECT: begin
                // A sop always restarts the frame, even mid-frame.
                if (accept && (state == COLLECT || in_sop)) begin
                    take    = 1'b1;
                    start   = in_sop;
                    discard = (state == COLLECT) && in_sop;
                    idx     = in_sop ? '0 : cnt;
                    bad_n   = (in_sop ? 1'b0 : bad) | (|in_error);
                    if (in_eop) begin
                        if (idx == LAST_BEAT) begin
                            state_n = FLUSH;
                            fcnt_n  = '0;
                        end else begin
                            discard = 1'b1;
                            state_n = IDLE;
                        end
                    end else if (idx == LAST_BEAT) begin
                        discard = 1'b1;
                        state_n = IDLE;
                    end else begin
                        state_n = COLLECT;
                        cnt_n   = idx + 1'b1;
                    end
                end
            end
            FLUSH: begin
                fcnt_n = fcnt + 1'b1;
                if (fcnt == 2'd3) begin
                    state_n   = IDLE;
                    commit    = !bad;
                    flush_err = bad;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    fft_mag_approx u_mag (
        .clk      (clk),
        .reset    (reset),
        .kill     (start),
        .beat_vld (take),
        .re       (in_real),
        .im       (in_imag),
        .exp_v    (exp_q),
        .idx      (idx),
        .mag_vld  (p_vld),
        .mag      (p_mag),
        .mag_idx  (p_idx)
    );

    // The sop beat's exponent is latched here and reaches the shifter two cycles later.
    always_ff @(posedge clk) begin
        if (reset) begin
            exp_q      <= '0;
            rd_mag     <= '0;
            frame_done <= 1'b0;
            sync_err   <= 1'b0;
            for (int i = 0; i < NUM_BARS; i++) begin
                work[i] <= '0;
                bank[i] <= '0;
            end
        end else begin
            if (start)
                exp_q <= in_exp;
            frame_done <= commit;
            sync_err   <= discard || flush_err;
            rd_mag     <= bank[rd_bar];
            if (start) begin
                for (int i = 0; i < NUM_BARS; i++)
                    work[i] <= '0;
            end else if (p_vld && !p_idx[BIN_W-1] && (p_mag > work[p_bar])) begin
                work[p_bar] <= p_mag;
            end
            if (commit)
                bank <= work;
        end
    end
endmodule

// File: tb/tb_fft_bar_binner.sv
// Directed frames with hand-computed bar banks; a monitor scores every frame_done/sync_err pulse and sweeps the bank.
module tb_fft_bar_binner;
    import fft_pkg::*;

    typedef logic [NUM_BARS-1:0][MAG_W-1:0] bank_t;
    typedef struct packed {
        logic        is_done;
        logic [31:0] cyc;
        bank_t       bank;
    } exp_t;

    logic                     clk = 1'b0;
    logic                     reset = 1'b1;
    logic                     in_valid = 1'b0;
    logic                     in_sop = 1'b0;
    logic                     in_eop = 1'b0;
    logic [1:0]               in_error = 2'b00;
    logic signed [DATA_W-1:0] in_real = '0;
    logic signed [DATA_W-1:0] in_imag = '0;
    logic signed [EXP_W-1:0]  in_exp = '0;
    logic                     in_ready;
    logic [BAR_W-1:0]         rd_bar = '0;
    logic [MAG_W-1:0]         rd_mag;
    logic                     frame_done;
    logic                     sync_err;

    exp_t q[$];
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    logic stim_done = 1'b0;
    logic stim_timeout = 1'b0;
    logic rst_q = 1'b1;

    fft_bar_binner dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_sop     (in_sop),
        .in_eop     (in_eop),
        .in_error   (in_error),
        .in_real    (in_real),
        .in_imag    (in_imag),
        .in_exp     (in_exp),
        .in_ready   (in_ready),
        .rd_bar     (rd_bar),
        .rd_mag     (rd_mag),
        .frame_done (frame_done),
        .sync_err   (sync_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= reset;
    end

    task automatic idle(input int n);
        in_valid = 1'b0;
        in_sop   = 1'b0;
        in_eop   = 1'b0;
        in_error = 2'b00;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Beats 0..len-1; at most two nonzero bins; returns the acceptance cycle of the last beat.
    task automatic send_frame(input int len, input int eop_at,
                              input int bin_a, input int re_a, input int im_a,
                              input int bin_b, input int re_b, input int im_b,
                              input int ex, input int err_at, output int t_last);
        t_last = 0;
        for (int i = 0; i < len; i++) begin
            int guard;
            in_valid = 1'b1;
            in_sop   = (i == 0);
            in_eop   = (i == eop_at);
            in_error = (i == err_at) ? 2'b01 : 2'b00;
            in_exp   = EXP_W'(ex);
            in_real  = (i == bin_a) ? DATA_W'(re_a) : (i == bin_b) ? DATA_W'(re_b) : '0;
            in_imag  = (i == bin_a) ? DATA_W'(im_a) : (i == bin_b) ? DATA_W'(im_b) : '0;
            guard = 0;
            while (!in_ready && guard < 100) begin
                @(posedge clk);
                #1;
                guard++;
            end
            if (guard >= 100)
                stim_timeout = 1'b1;
            t_last = cyc;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_ev(input logic is_done, input int c, input bank_t b);
        exp_t e;
        e.is_done = is_done;
        e.cyc     = 32'(c);
        e.bank    = b;
        q.push_back(e);
    endtask

    initial begin
        int    t;
        bank_t bk;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        idle(30);

        send_frame(1024, 1023, 40, 1000, 0, -1, 0, 0, 0, -1, t);
        bk = '0; bk[1] = 16'd1000;
        expect_ev(1'b1, t + 5, bk);
        idle(30);

        send_frame(1024, 1023, 5, 300, -400, -1, 0, 0, -2, -1, t);
        bk = '0; bk[0] = 16'd1900;
        expect_ev(1'b1, t + 5, bk);
        idle(30);

        send_frame(1024, 1023, 5, 300, -400, -1, 0, 0, 3, -1, t);
        bk = '0; bk[0] = 16'd59;
        expect_ev(1'b1, t + 5, bk);
        idle(30);

        send_frame(1024, 1023, 600, 5000, 0, -1, 0, 0, 0, -1, t);
        bk = '0;
        expect_ev(1'b1, t + 5, bk);
        idle(30);

        send_frame(1024, 1023, 32, 10, 0, 63, 20, 0, 0, -1, t);
        bk = '0; bk[1] = 16'd20;
        expect_ev(1'b1, t + 5, bk);
        idle(30);

        send_frame(1024, 1023, 100, -8388608, -8388608, -1, 0, 0, 0, -1, t);
        bk = '0; bk[3] = 16'hFFFF;
        expect_ev(1'b1, t + 5, bk);
        idle(30);

        // Early eop: discarded, bank keeps bar 3 saturated.
        send_frame(101, 100, 2, 4000, 0, -1, 0, 0, 0, -1, t);
        expect_ev(1'b0, t + 1, bk);
        idle(30);

        // Abandoned 500-beat frame, then a new sop on the very next beat.
        send_frame(500, -1, 3, 9999, 0, -1, 0, 0, 0, -1, t);
        expect_ev(1'b0, t + 2, bk);
        send_frame(1024, 1023, 40, 1000, 0, -1, 0, 0, 0, -1, t);
        bk = '0; bk[1] = 16'd1000;
        expect_ev(1'b1, t + 5, bk);
        idle(30);

        send_frame(1024, 1023, 5, 300, -400, -1, 0, 0, -2, 7, t);
        expect_ev(1'b0, t + 5, bk);
        idle(30);

        send_frame(300, -1, 10, 50, 0, -1, 0, 0, 0, -1, t);
        in_valid = 1'b0;
        reset    = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        idle(30);

        send_frame(1024, 1023, 200, 777, 0, -1, 0, 0, 0, -1, t);
        bk = '0; bk[6] = 16'd777;
        expect_ev(1'b1, t + 5, bk);
        idle(30);
        stim_done = 1'b1;
    end

    initial begin
        bank_t model;
        exp_t  e;
        logic  sweeping;
        logic  rst_armed;
        int    sw_i;
        int    got_kind;
        int    budget;
        model     = '0;
        sweeping  = 1'b0;
        rst_armed = 1'b0;
        sw_i      = 0;
        for (budget = 0; budget < 60000; budget++) begin
            @(negedge clk);
            if (stim_done && q.size() == 0 && !sweeping)
                break;
            if (sweeping) begin
                checks++;
                if (rd_mag !== model[sw_i]) begin
                    errors++;
                    $display("FAIL bar_%0d got=%0d want=%0d at cycle %0d", sw_i, rd_mag, model[sw_i], cyc);
                end
                sw_i++;
                if (sw_i < NUM_BARS) begin
                    rd_bar = BAR_W'(sw_i);
                end else begin
                    sweeping = 1'b0;
                    rd_bar   = BAR_W'(1);
                end
            end
            if (rst_q && !rst_armed) begin
                rst_armed = 1'b1;
                checks += 2;
                if (rd_mag !== '0) begin
                    errors++;
                    $display("FAIL reset_rd_mag got=%0d want=0", rd_mag);
                end
                if (in_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL reset_in_ready got=%b want=0", in_ready);
                end
            end
            if (!reset && rst_armed) begin
                rst_armed = 1'b0;
                checks++;
                if (in_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL post_reset_in_ready got=%b want=1", in_ready);
                end
                model    = '0;
                sweeping = 1'b1;
                sw_i     = 0;
                rd_bar   = '0;
            end
            if (frame_done === 1'b1 || sync_err === 1'b1) begin
                got_kind = (frame_done ? 1 : 0) + (sync_err ? 2 : 0);
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_pulse got=%0d want=none at cycle %0d", got_kind, cyc);
                end else begin
                    e = q.pop_front();
                    if (got_kind != (e.is_done ? 1 : 2)) begin
                        errors++;
                        $display("FAIL pulse_kind got=%0d want=%0d at cycle %0d", got_kind, e.is_done ? 1 : 2, cyc);
                    end
                    checks++;
                    if (32'(cyc) != e.cyc) begin
                        errors++;
                        $display("FAIL pulse_cycle got=%0d want=%0d", cyc, e.cyc);
                    end
                    if (e.is_done)
                        model = e.bank;
                    sweeping = 1'b1;
                    sw_i     = 0;
                    rd_bar   = '0;
                end
            end
        end
        checks++;
        if (budget >= 60000 || q.size() != 0) begin
            errors++;
            $display("FAIL run_timeout got=%0d pending want=0 pending", q.size());
        end
        checks++;
        if (stim_timeout !== 1'b0) begin
            errors++;
            $display("FAIL in_ready_wait got=timeout want=accepted");
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
